// File: rtl/memory_responder_if.sv
// Memory handshake bundle between the core (master) and the responder (slave).
interface memory_responder_if;
    logic        memory_enable;
    logic        memory_command;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [3:0]  memory_write_mask;
    logic        memory_ready;
    logic        memory_valid;
    logic [31:0] memory_read_data;
    logic        memory_fault;

    modport master (
        output memory_enable,
        output memory_command,
        output memory_address,
        output memory_write_data,
        output memory_write_mask,
        input  memory_ready,
        input  memory_valid,
        input  memory_read_data,
        input  memory_fault
    );

    modport slave (
        input  memory_enable,
        input  memory_command,
        input  memory_address,
        input  memory_write_data,
        input  memory_write_mask,
        output memory_ready,
        output memory_valid,
        output memory_read_data,
        output memory_fault
    );
endinterface

// File: rtl/memory_responder.sv
// Memory responder: word-organised RAM behind a ready/valid handshake with a
// fixed number of wait states and an address-window fault flag.
// One request outstanding at a time; the RAM is touched only at the accept edge.
module memory_responder #(
    parameter int unsigned WORDS   = 1024,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    memory_responder_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // Window size in bytes, one bit wider so that large windows cannot wrap.
    localparam logic [32:0] SPAN = 33'(WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             valid_q;
    logic             rd_ok_q;   // accepted access was an in-range read
    logic             fault_q;   // accepted access was out of range

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             wr_en;
    logic [31:0]      ram_rd;
    logic             unused_offset;

    // Unsigned wrap-around subtraction makes addresses below BASE fall out of range.
    assign offset        = bus.memory_address - BASE;
    assign in_range      = {1'b0, offset} < SPAN;
    assign idx           = offset[IDX_W+1:2];
    assign unused_offset = ^offset;
    assign accept        = !reset && (state_q == IDLE) && bus.memory_enable;
    assign wr_en         = accept && bus.memory_command && in_range;

    // One RAM per byte lane so each lane enable maps onto its own write port.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] lane_rd_q;

        // Lane write and registered read, both only at the accept edge.
        always_ff @(posedge clk) begin
            if (accept) begin
                if (wr_en && bus.memory_write_mask[gi]) begin
                    mem[idx] <= bus.memory_write_data[8*gi +: 8];
                end
                lane_rd_q <= mem[idx];
            end
        end

        assign ram_rd[8*gi +: 8] = lane_rd_q;
    end

    // Next-state logic: accept in IDLE, count down wait states, pulse once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.memory_enable) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; ready/valid are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rd_ok_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == RESPOND);
            if (accept) begin
                rd_ok_q <= !bus.memory_command && in_range;
                fault_q <= !in_range;
            end
        end
    end

    // Data and fault are qualified by valid so they read as zero outside the pulse.
    assign bus.memory_ready     = ready_q;
    assign bus.memory_valid     = valid_q;
    assign bus.memory_read_data = (valid_q && rd_ok_q) ? ram_rd : 32'h0;
    assign bus.memory_fault     = valid_q && fault_q;
endmodule
